// File: rtl/configure.sv
// ---------------------------------------------------------------------------
// configure -- shared types and constants for the bram arbiter slice.
//
// Contents:
//   mem_req_t    one memory request: {instr, addr[31:0], wdata[31:0], wstrb[3:0]}
//   arb_state_t  arbiter FSM states IDLE / BUSY_I / BUSY_D
//   GRANT_I/D    grant-id encoding, also used as the index of each port's
//                pending slot inside the arbiter
//   pick_winner  arbitration decision between the two request slots
// ---------------------------------------------------------------------------
package configure;

    typedef struct packed {
        logic        instr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } mem_req_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } arb_state_t;

    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

    localparam int NUM_PORTS = 2;

    // Winner among the eligible ports. With both eligible, either data has
    // fixed priority or the port that was not granted last time wins.
    // Only meaningful when at least one of pend_i / pend_d is set.
    function automatic logic pick_winner(
        input logic pend_i,
        input logic pend_d,
        input logic prio_d,
        input logic last_grant
    );
        logic win;
        if (pend_i && pend_d) begin
            if (prio_d) begin
                win = GRANT_D;
            end else if (last_grant == GRANT_I) begin
                win = GRANT_D;
            end else begin
                win = GRANT_I;
            end
        end else if (pend_d) begin
            win = GRANT_D;
        end else begin
            win = GRANT_I;
        end
        return win;
    endfunction

endpackage

// File: rtl/bram_req_slot.sv
// ---------------------------------------------------------------------------
// bram_req_slot -- single-entry pending-request buffer for one requester.
//
// Ports:
//   clk       in   clock, rising edge
//   rst       in   asynchronous reset, active-low
//   valid     in   request pulse from the requester
//   req       in   request payload presented with valid
//   clear     in   the buffered request completes this cycle
//   eff_pend  out  slot holds a request that is eligible for issue this
//                  cycle (includes a same-cycle capture)
//   eff_req   out  the request that would be issued this cycle
//
// A valid arriving while the slot is still occupied (and not completing)
// is a protocol violation and is dropped; the older request is kept.
// A valid arriving in the completion cycle refills the slot immediately.
// ---------------------------------------------------------------------------
module bram_req_slot
    import configure::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     valid,
    input  mem_req_t req,
    input  logic     clear,
    output logic     eff_pend,
    output mem_req_t eff_req
);

    logic     pend_reg;
    mem_req_t req_reg;
    logic     take;

    // Room for a new request if empty or the current one finishes now.
    assign take = valid && (!pend_reg || clear);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_reg <= 1'b0;
            req_reg  <= '0;
        end else begin
            if (take) begin
                pend_reg <= 1'b1;
                req_reg  <= req;
            end else if (clear) begin
                pend_reg <= 1'b0;
            end
        end
    end

    // Bypass lets a freshly captured request be issued in its capture cycle.
    assign eff_pend = take || (pend_reg && !clear);
    assign eff_req  = take ? req : req_reg;

endmodule

// File: rtl/bram_arbiter.sv
// ---------------------------------------------------------------------------
// bram_arbiter -- shares one single-port block RAM between the instruction
// fetch port (imem) and the data load/store port (dmem).
//
// Parameters:
//   prio_data  0 = round-robin under contention, 1 = data port always wins
//
// Ports:
//   rst              in   asynchronous reset, active-low
//   clk              in   clock, rising edge
//   imem_valid       in   instruction-port request pulse
//   imem_instr       in   instruction-fetch tag
//   imem_addr[31:0]  in   byte address
//   imem_wdata[31:0] in   write data
//   imem_wstrb[3:0]  in   byte strobes, 0 = read
//   imem_rdata[31:0] out  read data, valid with imem_ready (0 otherwise)
//   imem_ready       out  completion pulse
//   dmem_*                same set for the data port
//   bram_valid/instr/addr/wdata/wstrb  out  registered request to the bram
//   bram_rdata[31:0] in   bram read data
//   bram_ready       in   bram completion, the cycle after bram_valid
//
// Each port request is buffered in a bram_req_slot. The FSM issues one
// request at a time; when the bram completes it, the next winner is issued
// in the same cycle so the bram sees a transaction every two cycles.
// ---------------------------------------------------------------------------
module bram_arbiter
    import configure::*;
#(
    parameter bit prio_data = 1'b0
) (
    input  logic        rst,
    input  logic        clk,

    input  logic        imem_valid,
    input  logic        imem_instr,
    input  logic [31:0] imem_addr,
    input  logic [31:0] imem_wdata,
    input  logic [3:0]  imem_wstrb,
    output logic [31:0] imem_rdata,
    output logic        imem_ready,

    input  logic        dmem_valid,
    input  logic        dmem_instr,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_wdata,
    input  logic [3:0]  dmem_wstrb,
    output logic [31:0] dmem_rdata,
    output logic        dmem_ready,

    output logic        bram_valid,
    output logic        bram_instr,
    output logic [31:0] bram_addr,
    output logic [31:0] bram_wdata,
    output logic [3:0]  bram_wstrb,
    input  logic [31:0] bram_rdata,
    input  logic        bram_ready
);

    // Per-port signals, indexed by grant id (GRANT_I = imem, GRANT_D = dmem).
    logic [NUM_PORTS-1:0] port_valid;
    logic [NUM_PORTS-1:0] port_clear;
    logic [NUM_PORTS-1:0] eff_pend;
    mem_req_t             port_req [NUM_PORTS];
    mem_req_t             eff_req  [NUM_PORTS];

    arb_state_t state_reg;
    arb_state_t state_next;
    logic       last_grant_reg;
    logic       bram_valid_reg;
    mem_req_t   bram_req_reg;

    logic       decide;
    logic       issue;
    logic       winner;
    mem_req_t   issue_req;

    assign port_valid[GRANT_I] = imem_valid;
    assign port_valid[GRANT_D] = dmem_valid;
    assign port_req[GRANT_I]   = {imem_instr, imem_addr, imem_wdata, imem_wstrb};
    assign port_req[GRANT_D]   = {dmem_instr, dmem_addr, dmem_wdata, dmem_wstrb};

    // Completion is only honoured while a transaction is outstanding, so a
    // stray bram_ready in IDLE (e.g. left over from before reset) is dropped.
    assign port_clear[GRANT_I] = bram_ready && (state_reg == BUSY_I);
    assign port_clear[GRANT_D] = bram_ready && (state_reg == BUSY_D);

    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_slot
            bram_req_slot u_slot (
                .clk      (clk),
                .rst      (rst),
                .valid    (port_valid[gi]),
                .req      (port_req[gi]),
                .clear    (port_clear[gi]),
                .eff_pend (eff_pend[gi]),
                .eff_req  (eff_req[gi])
            );
        end
    endgenerate

    // A new issue decision is taken in IDLE or on the completion cycle.
    assign decide = (state_reg == IDLE) || (|port_clear);

    always_comb begin
        state_next = state_reg;
        issue      = 1'b0;
        winner     = pick_winner(eff_pend[GRANT_I], eff_pend[GRANT_D],
                                 prio_data, last_grant_reg);

        case (state_reg)
            IDLE, BUSY_I, BUSY_D: begin
                if (decide) begin
                    if (|eff_pend) begin
                        issue      = 1'b1;
                        state_next = (winner == GRANT_D) ? BUSY_D : BUSY_I;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign issue_req = eff_req[winner];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= IDLE;
            last_grant_reg <= GRANT_I;
            bram_valid_reg <= 1'b0;
            bram_req_reg   <= '0;
        end else begin
            state_reg      <= state_next;
            bram_valid_reg <= issue;
            if (issue) begin
                bram_req_reg   <= issue_req;
                last_grant_reg <= winner;
            end
        end
    end

    assign bram_valid = bram_valid_reg;
    assign bram_instr = bram_req_reg.instr;
    assign bram_addr  = bram_req_reg.addr;
    assign bram_wdata = bram_req_reg.wdata;
    assign bram_wstrb = bram_req_reg.wstrb;

    assign imem_ready = port_clear[GRANT_I];
    assign dmem_ready = port_clear[GRANT_D];

    // Read data is forced to 0 outside the completion pulse so every output
    // reads 0 while the arbiter is idle or held in reset.
    assign imem_rdata = imem_ready ? bram_rdata : 32'h0;
    assign dmem_rdata = dmem_ready ? bram_rdata : 32'h0;

endmodule

// File: tb/tb_bram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bram_arbiter -- directed bench for bram_arbiter. Two instances share the
// same requester stimulus: u_rr (round-robin) and u_pd (data priority), each
// with its own behavioural bram (ready one cycle after valid, byte writes).
// Inputs are driven 1 time unit after the rising edge; outputs are sampled
// on the falling edge.
// ---------------------------------------------------------------------------
module tb_bram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        iv, ii, dv, di;
    logic [31:0] ia, iw, da, dw;
    logic [3:0]  is, ds;
    logic        stale;
    logic        load_mem;

    logic [31:0] irdata_rr, drdata_rr, ba_rr, bw_rr, brd_rr;
    logic        iready_rr, dready_rr, bv_rr, binstr_rr, brdy_rr;
    logic [3:0]  bs_rr;
    logic [31:0] irdata_pd, drdata_pd, ba_pd, bw_pd, brd_pd;
    logic        iready_pd, dready_pd, bv_pd, binstr_pd, brdy_pd;
    logic [3:0]  bs_pd;

    logic [31:0] mem_rr [256];
    logic [31:0] mem_pd [256];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    bram_arbiter #(.prio_data(1'b0)) u_rr (
        .rst(rst), .clk(clk),
        .imem_valid(iv), .imem_instr(ii), .imem_addr(ia), .imem_wdata(iw),
        .imem_wstrb(is), .imem_rdata(irdata_rr), .imem_ready(iready_rr),
        .dmem_valid(dv), .dmem_instr(di), .dmem_addr(da), .dmem_wdata(dw),
        .dmem_wstrb(ds), .dmem_rdata(drdata_rr), .dmem_ready(dready_rr),
        .bram_valid(bv_rr), .bram_instr(binstr_rr), .bram_addr(ba_rr),
        .bram_wdata(bw_rr), .bram_wstrb(bs_rr), .bram_rdata(brd_rr),
        .bram_ready(brdy_rr)
    );

    bram_arbiter #(.prio_data(1'b1)) u_pd (
        .rst(rst), .clk(clk),
        .imem_valid(iv), .imem_instr(ii), .imem_addr(ia), .imem_wdata(iw),
        .imem_wstrb(is), .imem_rdata(irdata_pd), .imem_ready(iready_pd),
        .dmem_valid(dv), .dmem_instr(di), .dmem_addr(da), .dmem_wdata(dw),
        .dmem_wstrb(ds), .dmem_rdata(drdata_pd), .dmem_ready(dready_pd),
        .bram_valid(bv_pd), .bram_instr(binstr_pd), .bram_addr(ba_pd),
        .bram_wdata(bw_pd), .bram_wstrb(bs_pd), .bram_rdata(brd_pd),
        .bram_ready(brdy_pd)
    );

    // Behavioural brams: word i initialised to 0x1000_0000 | i. ready is not
    // reset; 'stale' injects a spurious ready pulse with junk read data.
    always @(posedge clk) begin
        brdy_rr <= bv_rr | stale;
        if (load_mem) begin
            for (int i = 0; i < 256; i++) mem_rr[i] <= 32'h1000_0000 | i;
        end else if (bv_rr) begin
            if (bs_rr == 4'h0) begin
                brd_rr <= mem_rr[ba_rr[9:2]];
            end else begin
                for (int b = 0; b < 4; b++)
                    if (bs_rr[b]) mem_rr[ba_rr[9:2]][8*b +: 8] <= bw_rr[8*b +: 8];
                brd_rr <= 32'h0;
            end
        end else if (stale) begin
            brd_rr <= 32'hCAFE_F00D;
        end
    end

    always @(posedge clk) begin
        brdy_pd <= bv_pd | stale;
        if (load_mem) begin
            for (int i = 0; i < 256; i++) mem_pd[i] <= 32'h1000_0000 | i;
        end else if (bv_pd) begin
            if (bs_pd == 4'h0) begin
                brd_pd <= mem_pd[ba_pd[9:2]];
            end else begin
                for (int b = 0; b < 4; b++)
                    if (bs_pd[b]) mem_pd[ba_pd[9:2]][8*b +: 8] <= bw_pd[8*b +: 8];
                brd_pd <= 32'h0;
            end
        end else if (stale) begin
            brd_pd <= 32'hCAFE_F00D;
        end
    end

    // One line per completed transaction on the round-robin instance.
    always @(negedge clk) begin
        if (rst === 1'b1 && iready_rr === 1'b1)
            $display("[TB] t=%0t rr imem done rdata=%08h", $time, irdata_rr);
        if (rst === 1'b1 && dready_rr === 1'b1)
            $display("[TB] t=%0t rr dmem done rdata=%08h", $time, drdata_rr);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, observed timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; stale = 1'b0; load_mem = 1'b1;
        iv = 0; ii = 0; ia = 0; iw = 0; is = 0;
        dv = 0; di = 0; da = 0; dw = 0; ds = 0;

        // ---- reset with the bram pulsing ready ----
        cyc(); cyc(); load_mem = 1'b0;
        stale = 1'b1; cyc(); stale = 1'b0; mid();
        chk("rst_imem_ready", {31'd0, iready_rr}, 32'd0);
        chk("rst_dmem_ready", {31'd0, dready_rr}, 32'd0);
        chk("rst_bram_valid", {31'd0, bv_rr}, 32'd0);
        chk("rst_bram_instr", {31'd0, binstr_rr}, 32'd0);
        chk("rst_bram_addr", ba_rr, 32'd0);
        chk("rst_bram_wdata", bw_rr, 32'd0);
        chk("rst_bram_wstrb", {28'd0, bs_rr}, 32'd0);
        chk("rst_imem_rdata", irdata_rr, 32'd0);
        chk("rst_dmem_rdata", drdata_rr, 32'd0);

        // ---- release, stale ready in IDLE is ignored ----
        cyc(); rst = 1'b1;
        stale = 1'b1; cyc(); stale = 1'b0; mid();
        chk("idle_stale_imem_ready", {31'd0, iready_rr}, 32'd0);
        chk("idle_stale_dmem_ready", {31'd0, dready_rr}, 32'd0);
        chk("idle_stale_bram_valid", {31'd0, bv_rr}, 32'd0);

        // ---- single read: imem 0x100 ----
        cyc(); iv = 1; ii = 1; ia = 32'h100; is = 0; mid();
        chk("sr_n_bram_valid", {31'd0, bv_rr}, 32'd0);
        chk("sr_n_imem_ready", {31'd0, iready_rr}, 32'd0);
        cyc(); iv = 0; mid();
        chk("sr_n1_bram_valid", {31'd0, bv_rr}, 32'd1);
        chk("sr_n1_bram_addr", ba_rr, 32'h100);
        chk("sr_n1_bram_instr", {31'd0, binstr_rr}, 32'd1);
        chk("sr_n1_bram_wstrb", {28'd0, bs_rr}, 32'd0);
        chk("sr_n1_imem_ready", {31'd0, iready_rr}, 32'd0);
        cyc(); mid();
        chk("sr_n2_imem_ready", {31'd0, iready_rr}, 32'd1);
        chk("sr_n2_imem_rdata", irdata_rr, 32'h1000_0040);
        chk("sr_n2_dmem_ready", {31'd0, dready_rr}, 32'd0);
        chk("sr_n2_bram_valid", {31'd0, bv_rr}, 32'd0);
        cyc(); mid();
        chk("sr_n3_imem_ready", {31'd0, iready_rr}, 32'd0);

        // ---- contention 1: last_grant = I -> data first on both ----
        cyc();
        iv = 1; ii = 1; ia = 32'h0; is = 0;
        dv = 1; di = 0; da = 32'h200; dw = 32'hDEAD_BEEF; ds = 4'hF;
        cyc(); iv = 0; dv = 0; mid();
        chk("c1_rr_bram_addr", ba_rr, 32'h200);
        chk("c1_rr_bram_wdata", bw_rr, 32'hDEAD_BEEF);
        chk("c1_rr_bram_wstrb", {28'd0, bs_rr}, 32'hF);
        chk("c1_rr_bram_instr", {31'd0, binstr_rr}, 32'd0);
        chk("c1_pd_bram_addr", ba_pd, 32'h200);
        cyc(); mid();
        chk("c1_rr_dmem_ready", {31'd0, dready_rr}, 32'd1);
        chk("c1_rr_imem_ready_early", {31'd0, iready_rr}, 32'd0);
        cyc(); mid();
        chk("c1_rr_bram_valid2", {31'd0, bv_rr}, 32'd1);
        chk("c1_rr_bram_addr2", ba_rr, 32'h0);
        chk("c1_rr_bram_instr2", {31'd0, binstr_rr}, 32'd1);
        chk("c1_rr_imem_ready_n3", {31'd0, iready_rr}, 32'd0);
        cyc(); mid();
        chk("c1_rr_imem_ready", {31'd0, iready_rr}, 32'd1);
        chk("c1_rr_imem_rdata", irdata_rr, 32'h1000_0000);
        chk("c1_rr_dmem_ready_n4", {31'd0, dready_rr}, 32'd0);

        // ---- dmem-only read of the written word (last_grant -> D) ----
        cyc(); dv = 1; di = 0; da = 32'h200; dw = 0; ds = 0;
        cyc(); dv = 0;
        cyc(); mid();
        chk("dr_rr_dmem_ready", {31'd0, dready_rr}, 32'd1);
        chk("dr_rr_dmem_rdata", drdata_rr, 32'hDEAD_BEEF);
        chk("dr_pd_dmem_rdata", drdata_pd, 32'hDEAD_BEEF);

        // ---- contention 2: round-robin now grants I, data priority grants D ----
        cyc();
        iv = 1; ii = 1; ia = 32'h100; is = 0;
        dv = 1; di = 0; da = 32'h204; dw = 0; ds = 0;
        cyc(); iv = 0; dv = 0; mid();
        chk("c2_rr_bram_addr", ba_rr, 32'h100);
        chk("c2_pd_bram_addr", ba_pd, 32'h204);
        cyc(); mid();
        chk("c2_rr_imem_ready", {31'd0, iready_rr}, 32'd1);
        chk("c2_rr_dmem_ready", {31'd0, dready_rr}, 32'd0);
        chk("c2_rr_imem_rdata", irdata_rr, 32'h1000_0040);
        chk("c2_pd_dmem_ready", {31'd0, dready_pd}, 32'd1);
        chk("c2_pd_imem_ready", {31'd0, iready_pd}, 32'd0);
        chk("c2_pd_dmem_rdata", drdata_pd, 32'h1000_0081);
        cyc(); mid();
        cyc(); mid();
        chk("c2_rr_dmem_ready2", {31'd0, dready_rr}, 32'd1);
        chk("c2_rr_dmem_rdata2", drdata_rr, 32'h1000_0081);
        chk("c2_pd_imem_ready2", {31'd0, iready_pd}, 32'd1);
        chk("c2_pd_imem_rdata2", irdata_pd, 32'h1000_0040);

        // ---- byte write 0x204 byte 1, then read back ----
        cyc(); dv = 1; di = 0; da = 32'h204; dw = 32'h0000_AB00; ds = 4'h2;
        cyc(); dv = 0; mid();
        chk("bw_bram_wstrb", {28'd0, bs_rr}, 32'h2);
        chk("bw_bram_wdata", bw_rr, 32'h0000_AB00);
        cyc(); mid();
        chk("bw_dmem_ready", {31'd0, dready_rr}, 32'd1);
        cyc(); dv = 1; da = 32'h204; dw = 0; ds = 0;
        cyc(); dv = 0;
        cyc(); mid();
        chk("br_dmem_ready", {31'd0, dready_rr}, 32'd1);
        chk("br_rr_dmem_rdata", drdata_rr, 32'h1000_AB81);
        chk("br_pd_dmem_rdata", drdata_pd, 32'h1000_AB81);

        // ---- back-to-back: 20 transactions, re-request on own ready ----
        // last_grant = D, so I goes first; completions at even cycles,
        // I at k%4==2 (2..38), D at k%4==0 (4..40), bram_valid at odd k.
        for (int k = 0; k <= 41; k++) begin
            cyc();
            iv = (k == 0) || ((k % 4 == 2) && (k <= 36));
            dv = (k == 0) || ((k % 4 == 0) && (k >= 4) && (k <= 36));
            ii = 1; ia = k * 4; is = 0;
            di = 0; da = 32'h80 + k * 4; ds = 0; dw = 0;
            mid();
            chk($sformatf("b2b_k%0d_bram_valid", k), {31'd0, bv_rr},
                ((k % 2 == 1) && (k <= 39)) ? 32'd1 : 32'd0);
            chk($sformatf("b2b_k%0d_imem_ready", k), {31'd0, iready_rr},
                ((k % 4 == 2) && (k <= 38)) ? 32'd1 : 32'd0);
            chk($sformatf("b2b_k%0d_dmem_ready", k), {31'd0, dready_rr},
                ((k % 4 == 0) && (k >= 4) && (k <= 40)) ? 32'd1 : 32'd0);
        end
        iv = 0; dv = 0;

        // ---- abort: reset while BUSY_D ----
        cyc(); dv = 1; di = 0; da = 32'h10; ds = 0; dw = 0;
        cyc(); dv = 0; mid();
        chk("ab_bram_valid", {31'd0, bv_rr}, 32'd1);
        chk("ab_bram_addr", ba_rr, 32'h10);
        cyc(); rst = 1'b0; #1;
        chk("ab_rst_bram_valid", {31'd0, bv_rr}, 32'd0);
        chk("ab_rst_dmem_ready", {31'd0, dready_rr}, 32'd0);
        mid();
        chk("ab_rst_dmem_ready_mid", {31'd0, dready_rr}, 32'd0);
        chk("ab_rst_dmem_rdata", drdata_rr, 32'd0);
        cyc(); rst = 1'b1; mid();
        chk("ab_post_dmem_ready", {31'd0, dready_rr}, 32'd0);
        cyc(); stale = 1'b1;
        cyc(); stale = 1'b0; mid();
        chk("ab_stale_dmem_ready", {31'd0, dready_rr}, 32'd0);
        chk("ab_stale_imem_ready", {31'd0, iready_rr}, 32'd0);
        chk("ab_stale_bram_valid", {31'd0, bv_rr}, 32'd0);
        cyc(); iv = 1; ii = 1; ia = 32'h8; is = 0; mid();
        cyc(); iv = 0; mid();
        chk("ab_rd_bram_valid", {31'd0, bv_rr}, 32'd1);
        chk("ab_rd_bram_addr", ba_rr, 32'h8);
        cyc(); mid();
        chk("ab_rd_imem_ready", {31'd0, iready_rr}, 32'd1);
        chk("ab_rd_imem_rdata", irdata_rr, 32'h1000_0002);
        chk("ab_rd_dmem_ready", {31'd0, dready_rr}, 32'd0);
        cyc(); cyc();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bram_arbiter.md
# bram_arbiter

Two-requester arbiter that shares the single-port on-chip block RAM between the instruction fetch port and the data load/store port. Each requester issues one-cycle `valid` pulses and waits for a one-cycle `ready`. The arbiter buffers one pending request per port, serialises them onto the bram port with registered issue, and routes the bram `ready`/`rdata` back to the granted requester. It sits between the core's memory ports and the bram instance.

## Interface

**Parameters**
- `prio_data`, default 0: 0 = round-robin when both ports are pending; 1 = data port always wins.

**Ports**
- `rst`  in  1: asynchronous reset, active-low.
- `clk`  in  1: single clock, rising edge.
- `imem_valid`  in  1: instruction request pulse.
- `imem_instr`  in  1: instruction-fetch tag.
- `imem_addr`  in  32: byte address.
- `imem_wdata`  in  32: write data.
- `imem_wstrb`  in  4: byte strobes; 0 means read.
- `imem_rdata`  out  32: read data, valid while `imem_ready`=1.
- `imem_ready`  out  1: completion pulse.
- `dmem_*`  same set as `imem_*`, for the data port.
- `bram_valid`, `bram_instr`, `bram_addr`, `bram_wdata`, `bram_wstrb`  out  1/1/32/32/4: registered request to bram.
- `bram_rdata`  in  32: bram read data.
- `bram_ready`  in  1: bram completion, asserted the cycle after `bram_valid`.

## Operation

**Capture**
- On `X_valid`=1, latch `{instr, addr, wdata, wstrb}` into the port's pending slot and set `pend_X`.
- A valid on a port whose slot is already pending is a protocol violation. It is ignored; the slot keeps the older request.
- A valid in the same cycle as that port's `X_ready` is legal and is captured.

**State machine:** `IDLE`, `BUSY_I`, `BUSY_D`.
- `IDLE`: if any pending (including same-cycle capture), issue the winner and move to `BUSY_I` or `BUSY_D`.
- `BUSY_X`: hold until `bram_ready`=1. On that cycle:
  - assert `X_ready`;
  - clear `pend_X`;
  - issue the next winner if any (back-to-back), otherwise go to `IDLE`.

**Issue**
- On the clock edge, drive the `bram_*` outputs from the winner's slot.
- `bram_valid`=1 for exactly one cycle per transaction.
- Record the winner in `last_grant`.

**Arbitration**
- Both pending with `prio_data`=0: grant the port that is not `last_grant`.
- Both pending with `prio_data`=1: grant data.
- `last_grant` resets to I, so data wins the first contention.

**Response**
- `X_ready = bram_ready & (state==BUSY_X)`, combinational.
- `X_rdata = bram_rdata` for both ports, combinational. It is meaningful only with `X_ready`.
- `bram_ready` in `IDLE` is ignored. This covers a stale bram pulse after reset, since bram `ready` is not reset.

## Timing

**Reset values:** all outputs 0; `state`=`IDLE`; `pend_I`=`pend_D`=0; `last_grant`=I.

**Latency**
- Uncontended: valid at cycle N, `bram_valid` at N+1, `X_ready` at N+2.
- Contended loser: `X_ready` 2 cycles after the winner's `ready`.

**Throughput:** one bram transaction per 2 cycles. `bram_valid` for the next transaction coincides with the cycle after the current `bram_ready`.

**Reset mid-transaction:** asserting `rst` clears all state immediately, with no `ready` emitted. An in-flight bram write may still complete in the bram.

**Simultaneous events**
- Both ports valid in `IDLE`: resolved by arbitration; the loser stays pending.
- Port valid in the same cycle as another port's completion: that port is eligible for back-to-back issue.

## Structure

- Shared package `configure`:
  - typedef `mem_req_t {instr, addr[31:0], wdata[31:0], wstrb[3:0]}`;
  - enum `arb_state_t {IDLE, BUSY_I, BUSY_D}`;
  - grant-id encoding `GRANT_I`=0, `GRANT_D`=1.
- One natural sub-module, `bram_req_slot`: a single-entry pending buffer with valid flag, capture, and clear on completion, instantiated twice.
- Arbiter FSM and output mux stay in `bram_arbiter`.

## Test plan

- **Reset:** hold `rst`=0 with the bram model pulsing `ready` → all outputs 0. Release reset, no request → no `X_ready` pulse.
- **Single read:** `imem_valid`, addr 0x100, wstrb 0 at N → `bram_valid`/addr 0x100/`instr`=1 at N+1; `imem_ready`=1 and `imem_rdata`=model[0x40] at N+2.
- **Simultaneous requests:** `imem` read 0x0 and `dmem` write 0x200 with data 0xDEADBEEF, wstrb 0xF, same cycle, `prio_data`=0 → data issued first, `dmem_ready` at N+2, `imem_ready` at N+4. Repeat → order alternates (I first). With `prio_data`=1 → data first both times.
- **Byte write then read:** `dmem` write 0x204 with wstrb 0x2, data 0x0000AB00, then read 0x204 → read returns prior word with byte 1 = 0xAB.
- **Back-to-back:** both ports re-request on the cycle of their `ready` for 20 transactions → `bram_valid` every 2 cycles, strict alternation, no lost or duplicated `ready`.
- **Abort:** assert `rst` in `BUSY_D` (after `bram_valid`) → no `dmem_ready`. A stale `bram_ready` after release is ignored. A subsequent `imem` read completes in 2 cycles.
